// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - data-memory responder: byte-enable word RAM behind a req/ready handshake with programmable wait states
//
// Optional feature macro: DM_BOUNDS_CHECK_EN (address range check, adds the err output)
//
// Ports:
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   synchronous active-high reset
//   req    in   1   access request, held by the initiator until ready
//   mem_w  in   1   1 = write, 0 = read
//   addr   in   32  byte address, word index = addr[ADDR_W+1:2]
//   wdata  in   32  store data
//   be     in   4   write byte enables, be[i] gates wdata[8i+7:8i]
//   rdata  out  32  load data, meaningful only while ready = 1
//   ready  out  1   one-cycle completion pulse
//   err    out  1   out-of-range access, coincident with ready (DM_BOUNDS_CHECK_EN only)
module dm_resp #(
    parameter int ADDR_W    = 7,
    parameter int LATENCY   = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready
`ifdef DM_BOUNDS_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]        cnt;
    logic              mem_w_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              oor_q;

    // Reset never touches the RAM; the initializer is the only preload.
    logic [31:0] ram [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx};

    logic oor_in;
`ifdef DM_BOUNDS_CHECK_EN
    assign oor_in = |addr[31:ADDR_W+2];
    logic unused_addr;
    assign unused_addr = ^addr[1:0];
    assign err = ready && oor_q;
`else
    // Upper address bits are dropped, so addresses alias modulo the RAM size.
    assign oor_in = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

    // With LATENCY = 0 the IDLE -> RESP edge is also the capture edge, so the
    // response data must come from the live inputs rather than the copies.
    logic              sel_w;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_idx;
    assign sel_w   = (state == IDLE) ? mem_w  : mem_w_q;
    assign sel_oor = (state == IDLE) ? oor_in : oor_q;
    assign sel_idx = (state == IDLE) ? addr[ADDR_W+1:2] : idx_q;

    assign ready = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                cnt <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nxt == RESP) begin
                rdata <= (sel_w || sel_oor) ? 32'h0 : ram[sel_idx];
            end
        end
    end

    // Request copies; WAIT and RESP use only these, never the live inputs.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            mem_w_q <= mem_w;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            oor_q   <= oor_in;
        end
    end

    // Writes commit on the edge that ends RESP, so a following read always
    // sees them; a reset on that same edge cancels the commit.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && mem_w_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - self-checking scoreboard bench for dm_resp (LATENCY 2 and LATENCY 0 instances)
module tb_dm_resp;

`ifdef DM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0;
    logic        err2, err0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dm_resp #(.ADDR_W(7), .LATENCY(2), .INIT_ZERO(1)) dut (
        .clk(clk), .reset(reset), .req(req2), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata2), .ready(ready2)
`ifdef DM_BOUNDS_CHECK_EN
        , .err(err2)
`endif
    );

    dm_resp #(.ADDR_W(7), .LATENCY(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata0), .ready(ready0)
`ifdef DM_BOUNDS_CHECK_EN
        , .err(err0)
`endif
    );

`ifndef DM_BOUNDS_CHECK_EN
    assign err2 = 1'b0;
    assign err0 = 1'b0;
`endif

    function automatic void push(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endfunction

    // Starts just after a rising edge; lat counts cycles from the accept cycle
    // (cycle 0) to the cycle where ready is seen.
    task automatic access(input bit fast, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat, output logic [31:0] rd, output logic e);
        mem_w = w; addr = a; wdata = d; be = b;
        if (fast) req0 = 1'b1; else req2 = 1'b1;
        lat = 0;
        rd  = 32'hxxxx_xxxx;
        e   = 1'bx;
        while (lat < 40) begin
            @(negedge clk);
            if (fast ? ready0 : ready2) begin
                rd = fast ? rdata0 : rdata2;
                e  = fast ? err0 : err2;
                break;
            end
            lat++;
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready2 !== 1'b0 || ready0 !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b/%b exp 0/0", ready2, ready0);
        end
        checks++;
        if (rdata2 !== 32'h0 || rdata0 !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", rdata2, rdata0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e; exp_t x;
        push(32'h0, 1'b0);
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL wr_rdata got %h exp %h", rd, x.data); end
        push(32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL rd_data got %h exp %h", rd, x.data); end
`ifdef DM_BOUNDS_CHECK_EN
        checks++;
        if (e !== x.err) begin errors++; $display("FAIL rd_err_inrange got %b exp %b", e, x.err); end
`endif
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic e; exp_t x;
        access(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, e);
        push(32'hDE22BE44, 1'b0);
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL be_0101 got %h exp %h", rd, x.data); end
        access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, e);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL be_0000_latency got %0d exp 3", lat); end
        push(32'hDE22BE44, 1'b0);
        access(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL be_0000 got %h exp %h", rd, x.data); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e; exp_t x;
        int cyc, last, n;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 4'hF, lat, rd, e);
            push(32'(i + 1), 1'b0);
        end
        cyc = 0; last = -1; n = 0;
        mem_w = 1'b0; addr = 32'h0; be = 4'h0; req2 = 1'b1;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            if (ready2) begin
                x = sb.pop_front();
                checks++;
                if (rdata2 !== x.data) begin
                    errors++; $display("FAIL b2b_data%0d got %h exp %h", n, rdata2, x.data);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 4) begin
                        errors++; $display("FAIL b2b_interval%0d got %0d exp 4", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
                @(posedge clk); #1;
                addr = addr + 32'd4;
                if (n == 4) req2 = 1'b0;
            end
            cyc++;
        end
        req2 = 1'b0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", n); end
        sb.delete();
    endtask

    task automatic test_latency0();
        int lat; logic [31:0] rd; logic e; exp_t x;
        push(32'h0, 1'b0);
        access(1'b1, 1'b1, 32'h1FC, 32'hA5A5A5A5, 4'hF, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lat0_wr_latency got %0d exp 1", lat); end
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL lat0_wr_rdata got %h exp %h", rd, x.data); end
        push(32'hA5A5A5A5, 1'b0);
        access(1'b1, 1'b0, 32'h1FC, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lat0_rd_latency got %0d exp 1", lat); end
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL lat0_rd_data got %h exp %h", rd, x.data); end
    endtask

    task automatic test_reset_abort();
        int lat; int seen; logic [31:0] rd; logic e; exp_t x;
        // Reset lands in the WAIT cycle of a write.
        mem_w = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; req2 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready2) seen++;
        end
        @(posedge clk); #1;
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_wait_ready got %0d pulses exp 0", seen); end
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL abort_rdata_reset got %h exp 0", rdata2); end
        push(32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL abort_wait_data got %h exp %h", rd, x.data); end
        // Reset lands in the RESP cycle of a write.
        mem_w = 1'b1; addr = 32'h40; wdata = 32'h0BADF00D; be = 4'hF; req2 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (ready2) seen = 1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req2 = 1'b0;
        checks++;
        if (seen !== 1) begin errors++; $display("FAIL abort_resp_ready got %0d exp 1", seen); end
        push(32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL abort_resp_data got %h exp %h", rd, x.data); end
    endtask

    task automatic test_bounds();
        int lat; logic [31:0] rd; logic e; exp_t x;
        push(32'h0, BOUNDS);
        access(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency got %0d exp 3", lat); end
`ifdef DM_BOUNDS_CHECK_EN
        checks++;
        if (e !== x.err) begin errors++; $display("FAIL oor_wr_err got %b exp %b", e, x.err); end
`endif
        push(BOUNDS ? 32'h1 : 32'hCAFEF00D, 1'b0);
        access(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data) begin errors++; $display("FAIL word0_after_oor got %h exp %h", rd, x.data); end
`ifdef DM_BOUNDS_CHECK_EN
        checks++;
        if (e !== x.err) begin errors++; $display("FAIL inrange_err got %b exp %b", e, x.err); end
        push(32'h0, 1'b1);
        access(1'b0, 1'b0, 32'h204, 32'h0, 4'h0, lat, rd, e);
        x = sb.pop_front();
        checks++;
        if (rd !== x.data || e !== x.err) begin
            errors++; $display("FAIL oor_rd got %h/%b exp %h/%b", rd, e, x.data, x.err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_latency0();
        test_reset_abort();
        test_bounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
